// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: FSM state encoding and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_share_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    localparam int ARB_N_REQ_DEF    = 4;
    localparam int ARB_MAX_HOLD_DEF = 64;

endpackage : alu_share_arbiter_pkg

// File: rtl/alu_share_arbiter_rr_pick.sv
// Cyclic first-set picker: scans req (minus excl_mask) from ptr upward, wrapping to 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; found=0 when no eligible request exists.
// Ports: req_i (request levels), ptr_i (start index), excl_mask_i (bits to ignore),
//        found_o (any eligible bit), idx_o (index of first eligible bit, 0 when none).
module alu_share_arbiter_rr_pick
    import alu_share_arbiter_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ_DEF,
    parameter int SEL_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic [N_REQ-1:0] excl_mask_i,
    output logic             found_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [N_REQ-1:0] cand;
    int               pos;
    logic [SEL_W-1:0] pos_idx;

    assign cand = req_i & ~excl_mask_i;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // ptr_i is always < N_REQ, so a single subtract performs the wrap.
            pos = int'(ptr_i) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_idx = pos[SEL_W-1:0];
            if (!found_o && cand[pos_idx]) begin
                found_o = 1'b1;
                idx_o   = pos_idx;
            end
        end
    end

endmodule : alu_share_arbiter_rr_pick

// File: rtl/alu_share_arbiter.sv
// Round-robin owner arbiter for one shared ALU/result mux; grant held until done or request drop.
// Latency: 1 cycle from request to registered grant; back-to-back handoff with no idle cycle.
// Backpressure: non-owners wait while a grant is held; optional ARB_TIMEOUT_EN forces release after MAX_HOLD cycles.
// Ports: clk, rst (sync, active-high), req[N_REQ], done (owner completion pulse),
//        gnt[N_REQ] (one-hot), sel[SEL_W] (owner / last owner), busy, timeout (forced-release pulse).
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int N_REQ    = ARB_N_REQ_DEF,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    if (SEL_W != $clog2(N_REQ)) begin : g_bad_sel_w
        $error("SEL_W must equal clog2(N_REQ)");
    end
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("MAX_HOLD must be at least 2");
    end

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic [SEL_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_excl;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    logic [SEL_W-1:0] ptr_after_owner;
    logic             owner_req;
    logic             force_rel;
    logic             new_grant;

    assign ptr_after_owner = (int'(sel_q) == N_REQ - 1) ? '0 : sel_q + 1'b1;
    assign owner_req       = req[sel_q];

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_q, hold_d;

    // A dropped owner request is an ordinary release, so only a still-requesting owner is forced off.
    assign force_rel = (hold_q == HOLD_W'(MAX_HOLD - 1)) && !done && owner_req;

    always_comb begin
        hold_d = hold_q;
        if (new_grant) begin
            hold_d = '0;
        end else if (state_q == ARB_OWNED) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    alu_share_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req_i       (req),
        .ptr_i       (pick_ptr),
        .excl_mask_i (pick_excl),
        .found_o     (pick_found),
        .idx_o       (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        new_grant = 1'b0;
        pick_ptr  = ptr_q;
        pick_excl = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    new_grant = 1'b1;
                    gnt_d     = N_REQ'(1) << pick_idx;
                    sel_d     = pick_idx;
                    busy_d    = 1'b1;
                    state_d   = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                // Owner is masked so any other requester wins; the owner is the fallback.
                pick_ptr  = ptr_after_owner;
                pick_excl = N_REQ'(1) << sel_q;
                if (done || !owner_req || force_rel) begin
                    ptr_d     = ptr_after_owner;
                    timeout_d = force_rel;
                    if (pick_found) begin
                        new_grant = 1'b1;
                        gnt_d     = N_REQ'(1) << pick_idx;
                        sel_d     = pick_idx;
                    end else if (owner_req) begin
                        new_grant = 1'b1;
                        gnt_d     = N_REQ'(1) << sel_q;
                    end else begin
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule : alu_share_arbiter

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (N_REQ=4, MAX_HOLD=8), expectations computed by hand.
// Latency: inputs change 1ns after a rising edge; outputs are checked 1ns after the following edge.
// Backpressure: n/a.
module tb_alu_share_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int total;
    int bad;

    alu_share_arbiter #(
        .N_REQ    (4),
        .SEL_W    (2),
        .MAX_HOLD (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_state gnt=%b busy=%b sel=%0d timeout=%b exp gnt=0000 busy=0 sel=0 timeout=0",
                     gnt, busy, sel, timeout);
        end
        // Owner 2 active, then reset mid-grant.
        req = 4'b0100;
        tick();
        total++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_pregrant gnt=%b sel=%0d busy=%b exp 0100/2/1", gnt, sel, busy);
        end
        rst = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0) begin
            bad++;
            $display("FAIL reset_midgrant gnt=%b busy=%b sel=%0d exp 0000/0/0", gnt, busy, sel);
        end
        rst = 1'b0;
        tick();
        total++;
        if (gnt !== 4'b0100 || sel !== 2'd2) begin
            bad++;
            $display("FAIL reset_regrant gnt=%b sel=%0d exp 0100/2", gnt, sel);
        end
    endtask

    task automatic test_single();
        do_reset();
        // done while idle must not create a grant.
        done = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_done gnt=%b busy=%b exp 0000/0", gnt, busy);
        end
        done = 1'b0;
        req  = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010 || sel !== 2'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_grant gnt=%b sel=%0d busy=%b exp 0010/1/1", gnt, sel, busy);
        end
        // done and request drop together: one release, back to idle.
        done = 1'b1;
        req  = 4'b0000;
        tick();
        done = 1'b0;
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd1) begin
            bad++;
            $display("FAIL single_release gnt=%b busy=%b sel=%0d exp 0000/0/1", gnt, busy, sel);
        end
        tick();
        total++;
        if (gnt !== 4'b0000 || sel !== 2'd1) begin
            bad++;
            $display("FAIL single_idle_hold gnt=%b sel=%0d exp 0000/1", gnt, sel);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_gnt [5];
        exp_gnt[0] = 4'b0001;
        exp_gnt[1] = 4'b0010;
        exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000;
        exp_gnt[4] = 4'b0001;
        do_reset();
        req = 4'b1111;
        tick();
        total++;
        if (gnt !== exp_gnt[0] || busy !== 1'b1) begin
            bad++;
            $display("FAIL rot_first gnt=%b busy=%b exp %b/1", gnt, busy, exp_gnt[0]);
        end
        done = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            total++;
            if (gnt !== exp_gnt[k] || busy !== 1'b1 || sel !== 2'(k % 4)) begin
                bad++;
                $display("FAIL rot_step k=%0d gnt=%b busy=%b sel=%0d exp %b/1/%0d",
                         k, gnt, busy, sel, exp_gnt[k], k % 4);
            end
        end
        done = 1'b0;
        req  = 4'b0000;
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rot_drain gnt=%b busy=%b exp 0000/0", gnt, busy);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b1010;
        tick();
        total++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            bad++;
            $display("FAIL wd_hold gnt=%b sel=%0d exp 0010/1", gnt, sel);
        end
        req = 4'b1000;
        tick();
        total++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || busy !== 1'b1) begin
            bad++;
            $display("FAIL wd_handoff gnt=%b sel=%0d busy=%b exp 1000/3/1", gnt, sel, busy);
        end
        // Owner 3 withdraws; pointer wraps to 0, so 0 wins before 1.
        req = 4'b0011;
        tick();
        total++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            bad++;
            $display("FAIL wd_ptr_first gnt=%b sel=%0d exp 0001/0", gnt, sel);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        total++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            bad++;
            $display("FAIL wd_ptr_second gnt=%b sel=%0d exp 0010/1", gnt, sel);
        end
    endtask

    task automatic test_regrant();
        do_reset();
        req = 4'b0001;
        tick();
        done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (gnt !== 4'b0001 || busy !== 1'b1 || sel !== 2'd0) begin
                bad++;
                $display("FAIL regrant k=%0d gnt=%b busy=%b sel=%0d exp 0001/1/0", k, gnt, busy, sel);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0101;
        total++;
        if (gnt !== 4'b0100 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_grant gnt=%b timeout=%b exp 0100/0", gnt, timeout);
        end
        // Seven more owned cycles: still held, no timeout.
        for (int k = 1; k < 8; k++) begin
            tick();
            total++;
            if (gnt !== 4'b0100 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL to_hold k=%0d gnt=%b timeout=%b exp 0100/0", k, gnt, timeout);
            end
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        total++;
        if (gnt !== 4'b0001 || timeout !== 1'b1 || sel !== 2'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL to_force gnt=%b timeout=%b sel=%0d busy=%b exp 0001/1/0/1", gnt, timeout, sel, busy);
        end
        tick();
        total++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_pulse_end gnt=%b timeout=%b exp 0001/0", gnt, timeout);
        end
`else
        for (int k = 0; k < 4; k++) begin
            total++;
            if (gnt !== 4'b0100 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL to_disabled k=%0d gnt=%b timeout=%b exp 0100/0", k, gnt, timeout);
            end
            tick();
        end
`endif
        req = 4'b0000;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_withdraw();
        test_regrant();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_share_arbiter
